craps_ctrl: RTL and testbench
=============================

Name: craps_ctrl

Overview:
Game sequencer for the two-die craps datapath. It runs free-running die counters, captures a roll on the player's button, and scores it under come-out/point rules. It then drives the die values and a one-cycle refresh enable to the seven-segment display stage. It sits between the debounced push-button inputs and the display driver.

Parameters:
ROLL_CNT_W, 8, width of the saturating roll counter output rolls.

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high; clears all state
roll  input  1  debounced, synchronous roll button level
new_game  input  1  synchronous level; restarts the game
dice1  output  4  captured die 1 value: 0 = blank, 1..6 = face
dice2  output  4  captured die 2 value: 0 = blank, 1..6 = face
disp_en  output  1  one-cycle display refresh strobe
point  output  4  established point: 0 = none, 4..10 otherwise
win  output  1  high while in WIN
lose  output  1  high while in LOSE
rolls  output  ROLL_CNT_W  rolls taken this game, saturating

Behaviour:
- Reset is asynchronous and active-high on reset; clock is clock. On reset:
  - dice1 = dice2 = 0, point = 0, win = lose = 0, disp_en = 0, rolls = 0
  - state = COMEOUT, c1 = c2 = 1, roll_q = 0
- Internal die counters c1, c2 run over 1..6 and are never 0:
  - c1 advances every clock, wrapping 6 -> 1.
  - c2 advances only on the edge where c1 wraps 6 -> 1.
  - After n edges from reset: c1 = (n mod 6)+1, c2 = ((n div 6) mod 6)+1.
- roll_q registers roll. roll_rise = roll & ~roll_q.
- sum = c1 + c2, 4-bit, range 2..12.
- Capture (on roll_rise, in COMEOUT or POINT only):
  - At that edge: dice1 <= c1, dice2 <= c2, rolls <= rolls+1 (saturates at all-ones), state and point updated from sum.
  - disp_en is registered high for exactly the cycle after the capture edge. Latency is 1 clock from the sampled rise.
- FSM states: COMEOUT, POINT, WIN, LOSE.
  - COMEOUT:
    - sum 7 or 11 -> WIN
    - sum 2, 3 or 12 -> LOSE
    - otherwise point <= sum, -> POINT
  - POINT:
    - sum == point -> WIN
    - sum == 7 -> LOSE
    - otherwise stay; point unchanged
  - WIN / LOSE: roll is ignored. No capture, no disp_en, rolls unchanged.
- win and lose are registered decodes of state. They are never both high.
- new_game, any state:
  - next edge -> COMEOUT; point, rolls, win, lose cleared
  - dice1 and dice2 are held, no disp_en
  - c1 and c2 keep running
- new_game and roll_rise on the same edge: new_game takes priority and the roll is discarded. roll_q still updates, so a held button does not re-trigger.
- A held roll button produces one capture only. A new rise is required.
- Reset mid-game: immediate return to the reset values above, regardless of the roll level.

Optional Feature:
Macro CRAPS_ROLL_ANIM_EN.
- Defined:
  - While roll is high in COMEOUT or POINT, dice1/dice2 track c1/c2 every cycle and disp_en is held high (animation).
  - Capture and scoring occur on the falling edge instead: roll_fall = ~roll & roll_q. This uses the c1/c2 values at that edge, with the usual 1-cycle disp_en pulse.
  - rolls increments on the fall.
  - new_game while held stops the animation and discards the pending roll.
- Undefined: rise-triggered capture exactly as above; no animation logic is synthesised.

Test Plan:
- Reset, then idle 20 cycles -> dice1 = dice2 = 0, point = 0, win = lose = 0, disp_en never high, rolls = 0.
- Time roll_rise so (c1,c2) = (3,4) in COMEOUT -> next cycle dice1 = 3, dice2 = 4, disp_en one cycle, win = 1, rolls = 1. A further rise causes no change.
- COMEOUT roll (2,4) -> point = 6, state POINT. Roll (1,3): stays POINT, point = 6. Roll (5,1): win = 1, rolls = 3.
- COMEOUT roll (6,6) -> lose = 1. Then new_game -> point = 0, win = lose = 0, rolls = 0, dice1/dice2 still 6/6.
- Point 8, then new_game and roll_rise on the same edge -> COMEOUT, rolls = 0, no disp_en. Hold roll high 10 cycles -> no capture.
- Assert reset while in POINT with roll high -> all outputs at reset values immediately. Drive 300 captures with the counter width at 8 -> rolls saturates at 255.

Source files
------------

// File: rtl/craps_ctrl.sv
// craps_ctrl: two-die craps game sequencer.
// Free-running die counters are sampled on a roll-button rise and scored
// under come-out/point rules. The captured dice and a one-cycle refresh
// strobe are driven to the seven-segment display stage.
// Optional build macro CRAPS_ROLL_ANIM_EN: the dice animate while the button
// is held, and capture/scoring move to the button release.
module craps_ctrl #(
  parameter int ROLL_CNT_W = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  roll,
  input  logic                  new_game,
  output logic [3:0]            dice1,
  output logic [3:0]            dice2,
  output logic                  disp_en,
  output logic [3:0]            point,
  output logic                  win,
  output logic                  lose,
  output logic [ROLL_CNT_W-1:0] rolls
);

  typedef enum logic [1:0] {COMEOUT, POINT, WIN, LOSE} state_t;

  state_t                  state, state_nxt;
  logic [2:0]              c1, c2;
  logic                    roll_q;
  logic                    roll_rise;
  logic [3:0]              sum;
  logic                    playable;
  logic                    capture;
  logic [3:0]              dice1_nxt, dice2_nxt, point_nxt;
  logic [ROLL_CNT_W-1:0]   rolls_nxt;
  logic                    disp_en_nxt;

  // Saturating increment for the roll counter: holds at all-ones.
  function automatic logic [ROLL_CNT_W-1:0] sat_inc(input logic [ROLL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign sum       = {1'b0, c1} + {1'b0, c2};
  assign playable  = (state == COMEOUT) || (state == POINT);
  assign roll_rise = roll & ~roll_q;

`ifdef CRAPS_ROLL_ANIM_EN
  logic roll_fall;
  logic animate;
  logic pend_q, pend_nxt;

  assign roll_fall = ~roll & roll_q;
  // A press only counts if it started while the game was playable and was
  // not cancelled by new_game; pend_q remembers that across the hold.
  assign animate   = playable & ~new_game & roll & (roll_rise | pend_q);
  assign capture   = playable & ~new_game & roll_fall & pend_q;

  // Pending-press tracker: armed by an accepted press, dropped on release or new game.
  always_comb begin
    pend_nxt = pend_q;
    if (new_game)       pend_nxt = 1'b0;
    else if (animate)   pend_nxt = 1'b1;
    else if (roll_fall) pend_nxt = 1'b0;
  end

  // Pending-press register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) pend_q <= 1'b0;
    else       pend_q <= pend_nxt;
  end
`else
  assign capture = playable & ~new_game & roll_rise;
`endif

  // Die counters: c1 steps every clock, c2 steps when c1 wraps 6 -> 1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      c1 <= 3'd1;
      c2 <= 3'd1;
    end else if (c1 == 3'd6) begin
      c1 <= 3'd1;
      c2 <= (c2 == 3'd6) ? 3'd1 : c2 + 3'd1;
    end else begin
      c1 <= c1 + 3'd1;
    end
  end

  // Next-state and output decode; new_game overrides any roll on the same edge.
  always_comb begin
    state_nxt   = state;
    point_nxt   = point;
    rolls_nxt   = rolls;
    dice1_nxt   = dice1;
    dice2_nxt   = dice2;
    disp_en_nxt = capture;
`ifdef CRAPS_ROLL_ANIM_EN
    disp_en_nxt = capture | animate;
`endif
    if (new_game) begin
      state_nxt = COMEOUT;
      point_nxt = 4'd0;
      rolls_nxt = '0;
    end else if (capture) begin
      dice1_nxt = {1'b0, c1};
      dice2_nxt = {1'b0, c2};
      rolls_nxt = sat_inc(rolls);
      case (state)
        COMEOUT: begin
          if (sum == 4'd7 || sum == 4'd11)                      state_nxt = WIN;
          else if (sum == 4'd2 || sum == 4'd3 || sum == 4'd12)  state_nxt = LOSE;
          else begin
            point_nxt = sum;
            state_nxt = POINT;
          end
        end
        POINT: begin
          if (sum == point)      state_nxt = WIN;
          else if (sum == 4'd7)  state_nxt = LOSE;
        end
        default: state_nxt = state;
      endcase
    end
`ifdef CRAPS_ROLL_ANIM_EN
    else if (animate) begin
      dice1_nxt = {1'b0, c1};
      dice2_nxt = {1'b0, c2};
    end
`endif
  end

  // State, button history and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= COMEOUT;
      roll_q  <= 1'b0;
      dice1   <= 4'd0;
      dice2   <= 4'd0;
      point   <= 4'd0;
      rolls   <= '0;
      disp_en <= 1'b0;
      win     <= 1'b0;
      lose    <= 1'b0;
    end else begin
      state   <= state_nxt;
      roll_q  <= roll;
      dice1   <= dice1_nxt;
      dice2   <= dice2_nxt;
      point   <= point_nxt;
      rolls   <= rolls_nxt;
      disp_en <= disp_en_nxt;
      win     <= (state_nxt == WIN);
      lose    <= (state_nxt == LOSE);
    end
  end

endmodule

// File: tb/tb_craps_ctrl.sv
// tb_craps_ctrl: directed bench for craps_ctrl (default build).
// Rolls are timed against a bench-side edge counter so the captured dice
// values are known in advance: c1 = (n mod 6)+1, c2 = ((n div 6) mod 6)+1.
module tb_craps_ctrl;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         roll = 1'b0;
  logic         new_game = 1'b0;
  logic [3:0]   dice1, dice2, point;
  logic         disp_en, win, lose;
  logic [W-1:0] rolls;

  int n;
  int checks = 0;
  int failures = 0;

  craps_ctrl #(.ROLL_CNT_W(W)) dut (
    .clock(clock), .reset(reset), .roll(roll), .new_game(new_game),
    .dice1(dice1), .dice2(dice2), .disp_en(disp_en), .point(point),
    .win(win), .lose(lose), .rolls(rolls)
  );

  always #5 clock = ~clock;

  // Edges seen since reset release, used to predict the die counters.
  always @(posedge clock or posedge reset) begin
    if (reset) n <= 0;
    else       n <= n + 1;
  end

  // Raise roll so the next edge samples (a,b); returns at the negedge after capture.
  task automatic roll_at(input int a, input int b);
    int  target;
    bit  found;
    target = (b - 1) * 6 + (a - 1);
    found  = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clock);
      if ((n % 36) == target) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL roll_at_timeout got_n=%0d required_mod36=%0d", n, target);
    end
    roll = 1'b1;
    @(negedge clock);
    roll = 1'b0;
  endtask

  task automatic do_new_game();
    @(negedge clock);
    new_game = 1'b1;
    @(negedge clock);
    new_game = 1'b0;
  endtask

  task automatic test_reset();
    bit saw_en;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if ({dice1, dice2, point, disp_en, win, lose} !== 15'd0 || rolls !== 8'd0) begin
      failures++; $display("FAIL reset_held got d1=%0d d2=%0d pt=%0d en=%0b w=%0b l=%0b r=%0d required all 0", dice1, dice2, point, disp_en, win, lose, rolls); end
    #2 reset = 1'b0;
    saw_en = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (disp_en !== 1'b0) saw_en = 1'b1;
    end
    checks++; if (saw_en) begin failures++; $display("FAIL reset_idle_disp_en got=1 required=0"); end
    checks++; if (dice1 !== 4'd0 || dice2 !== 4'd0) begin failures++; $display("FAIL reset_idle_dice got=%0d/%0d required=0/0", dice1, dice2); end
    checks++; if (point !== 4'd0 || win !== 1'b0 || lose !== 1'b0 || rolls !== 8'd0) begin
      failures++; $display("FAIL reset_idle_state got pt=%0d w=%0b l=%0b r=%0d required 0/0/0/0", point, win, lose, rolls); end
  endtask

  task automatic test_comeout_win();
    roll_at(3, 4);
    checks++; if (dice1 !== 4'd3 || dice2 !== 4'd4) begin failures++; $display("FAIL cw_dice got=%0d/%0d required=3/4", dice1, dice2); end
    checks++; if (disp_en !== 1'b1) begin failures++; $display("FAIL cw_disp_en got=%0b required=1", disp_en); end
    checks++; if (win !== 1'b1 || lose !== 1'b0) begin failures++; $display("FAIL cw_win got w=%0b l=%0b required w=1 l=0", win, lose); end
    checks++; if (rolls !== 8'd1) begin failures++; $display("FAIL cw_rolls got=%0d required=1", rolls); end
    @(negedge clock);
    checks++; if (disp_en !== 1'b0) begin failures++; $display("FAIL cw_disp_en_pulse got=%0b required=0", disp_en); end
    roll = 1'b1;
    @(negedge clock);
    roll = 1'b0;
    checks++; if (dice1 !== 4'd3 || dice2 !== 4'd4 || rolls !== 8'd1 || disp_en !== 1'b0 || win !== 1'b1) begin
      failures++; $display("FAIL cw_ignored got d=%0d/%0d r=%0d en=%0b w=%0b required 3/4 1 0 1", dice1, dice2, rolls, disp_en, win); end
  endtask

  task automatic test_comeout_table();
    int ta [6] = '{5, 1, 1, 6, 2, 4};
    int tb [6] = '{6, 1, 2, 6, 3, 6};
    int tw [6] = '{1, 0, 0, 0, 0, 0};
    int tl [6] = '{0, 1, 1, 1, 0, 0};
    int tp [6] = '{0, 0, 0, 0, 5, 10};
    for (int i = 0; i < 6; i++) begin
      do_new_game();
      roll_at(ta[i], tb[i]);
      checks++;
      if (win !== tw[i][0] || lose !== tl[i][0] || point !== tp[i][3:0] || rolls !== 8'd1) begin
        failures++;
        $display("FAIL table_%0d_%0d got w=%0b l=%0b pt=%0d r=%0d required w=%0d l=%0d pt=%0d r=1",
                 ta[i], tb[i], win, lose, point, rolls, tw[i], tl[i], tp[i]);
      end
    end
  endtask

  task automatic test_point();
    do_new_game();
    roll_at(2, 4);
    checks++; if (point !== 4'd6 || win !== 1'b0 || lose !== 1'b0) begin failures++; $display("FAIL pt_set got pt=%0d w=%0b l=%0b required 6/0/0", point, win, lose); end
    roll_at(1, 3);
    checks++; if (point !== 4'd6 || win !== 1'b0 || lose !== 1'b0 || rolls !== 8'd2 || dice1 !== 4'd1 || dice2 !== 4'd3) begin
      failures++; $display("FAIL pt_stay got pt=%0d w=%0b l=%0b r=%0d d=%0d/%0d required 6/0/0 2 1/3", point, win, lose, rolls, dice1, dice2); end
    roll_at(5, 1);
    checks++; if (win !== 1'b1 || lose !== 1'b0 || rolls !== 8'd3) begin failures++; $display("FAIL pt_win got w=%0b l=%0b r=%0d required 1/0/3", win, lose, rolls); end
    do_new_game();
    roll_at(4, 4);
    roll_at(3, 4);
    checks++; if (win !== 1'b0 || lose !== 1'b1 || point !== 4'd8) begin failures++; $display("FAIL pt_seven got w=%0b l=%0b pt=%0d required 0/1/8", win, lose, point); end
  endtask

  task automatic test_lose_newgame();
    do_new_game();
    roll_at(6, 6);
    checks++; if (lose !== 1'b1 || win !== 1'b0) begin failures++; $display("FAIL ln_lose got w=%0b l=%0b required 0/1", win, lose); end
    do_new_game();
    checks++; if (point !== 4'd0 || win !== 1'b0 || lose !== 1'b0 || rolls !== 8'd0) begin
      failures++; $display("FAIL ln_cleared got pt=%0d w=%0b l=%0b r=%0d required 0/0/0/0", point, win, lose, rolls); end
    checks++; if (dice1 !== 4'd6 || dice2 !== 4'd6 || disp_en !== 1'b0) begin
      failures++; $display("FAIL ln_dice_held got d=%0d/%0d en=%0b required 6/6 0", dice1, dice2, disp_en); end
  endtask

  task automatic test_collision();
    bit bad;
    roll_at(4, 4);
    checks++; if (point !== 4'd8) begin failures++; $display("FAIL col_point8 got=%0d required=8", point); end
    @(negedge clock);
    new_game = 1'b1;
    roll = 1'b1;
    @(negedge clock);
    new_game = 1'b0;
    checks++; if (rolls !== 8'd0 || point !== 4'd0 || disp_en !== 1'b0 || win !== 1'b0 || lose !== 1'b0 || dice1 !== 4'd4 || dice2 !== 4'd4) begin
      failures++; $display("FAIL col_newgame got r=%0d pt=%0d en=%0b w=%0b l=%0b d=%0d/%0d required 0 0 0 0 0 4/4", rolls, point, disp_en, win, lose, dice1, dice2); end
    bad = 1'b0;
    repeat (10) begin
      @(negedge clock);
      if (disp_en !== 1'b0 || rolls !== 8'd0) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL col_held_capture got en=%0b r=%0d required 0/0", disp_en, rolls); end
    roll = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset_midgame();
    do_new_game();
    roll_at(2, 2);
    checks++; if (point !== 4'd4) begin failures++; $display("FAIL rm_point4 got=%0d required=4", point); end
    @(negedge clock);
    roll = 1'b1;
    #2 reset = 1'b1;
    #1;
    checks++; if ({dice1, dice2, point, disp_en, win, lose} !== 15'd0 || rolls !== 8'd0) begin
      failures++; $display("FAIL rm_async got d=%0d/%0d pt=%0d en=%0b w=%0b l=%0b r=%0d required all 0", dice1, dice2, point, disp_en, win, lose, rolls); end
    roll = 1'b0;
    @(negedge clock);
    #2 reset = 1'b0;
  endtask

  task automatic test_saturation();
    int exp;
    roll_at(1, 3);
    for (int i = 2; i <= 300; i++) begin
      roll_at(6, 6);
      if (i == 254 || i == 255 || i == 256 || i == 300) begin
        exp = (i > 255) ? 255 : i;
        checks++;
        if (rolls !== exp[W-1:0]) begin failures++; $display("FAIL sat_rolls_%0d got=%0d required=%0d", i, rolls, exp); end
      end
    end
    checks++; if (point !== 4'd4 || win !== 1'b0 || lose !== 1'b0) begin
      failures++; $display("FAIL sat_state got pt=%0d w=%0b l=%0b required 4/0/0", point, win, lose); end
  endtask

  initial begin
    test_reset();
    test_comeout_win();
    test_comeout_table();
    test_point();
    test_lose_newgame();
    test_collision();
    test_reset_midgame();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
